// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : PC owner and prefetch FIFO filler for a single-cycle instruction
//            memory. Shares the memory read port with a debug/loader reader.
//            Optional macro FETCH_CNT_EN adds the fetch_cnt push counter.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DBG  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    state_t               r_ret, w_ret_nxt;
    logic [31:0]          r_pc;
    logic [31:0]          r_pc_q  [FIFO_DEPTH];
    logic [31:0]          r_ins_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_dbg_ack;
    logic [31:0]          r_dbg_rdata;

    logic                 w_fetch, w_flush, w_pop, w_space, w_dbg_ok;
    logic                 w_unused;

    assign w_unused  = ^{dbg_addr[1:0], redirect_pc[1:0]};
    assign out_valid = (r_count != '0);
    assign out_pc    = out_valid ? r_pc_q[r_rd_ptr]  : '0;
    assign out_instr = out_valid ? r_ins_q[r_rd_ptr] : '0;
    assign dbg_ack   = r_dbg_ack;
    assign dbg_rdata = r_dbg_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
        end
    end

    // The ack cycle blocks DBG re-entry, so a held request cannot steal the
    // port twice in a row and the returning RUN cycle always gets its slot.
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_fetch     = 1'b0;
        w_flush     = 1'b0;
        imem_addr   = r_pc;
        w_pop       = out_valid && out_ready;
        w_space     = (r_count < c_DEPTH) || w_pop;
        w_dbg_ok    = dbg_req && !redirect_valid && !r_dbg_ack;
        case (r_state)
            S_IDLE: begin
                if (w_dbg_ok) begin
                    w_state_nxt = S_DBG;
                    w_ret_nxt   = start ? S_RUN : S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_flush = redirect_valid;
                w_fetch = !redirect_valid && w_space;
                if (w_dbg_ok) begin
                    w_state_nxt = S_DBG;
                    w_ret_nxt   = S_RUN;
                end
            end
            S_DBG: begin
                imem_addr   = {dbg_addr[31:2], 2'b00};
                w_flush     = redirect_valid;
                w_state_nxt = r_ret;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_fetch) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pc_q[i]  <= '0;
                r_ins_q[i] <= '0;
            end
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fetch) begin
                r_pc_q[r_wr_ptr]  <= r_pc;
                r_ins_q[r_wr_ptr] <= imem_rdata;
                r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_fetch) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_dbg_ack <= (r_state == S_DBG);
            if (r_state == S_DBG) begin
                r_dbg_rdata <= imem_rdata;
            end
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
        end else if (w_fetch) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Brief    : Directed plus randomized bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam int D = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0, dbg_req = 1'b0;
    logic [31:0] redirect_pc = '0, dbg_addr = '0;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, dbg_rdata;
    logic        out_valid, dbg_ack;

    logic        rst_w = 1'b0, start_w = 1'b0, out_ready_w = 1'b0;
    logic [31:0] imem_addr_w, imem_rdata_w, out_instr_w, out_pc_w, dbg_rdata_w;
    logic        out_valid_w, dbg_ack_w;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt, fetch_cnt_w;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign imem_rdata_w = mem_word(imem_addr_w);

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(D)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(fetch_cnt)
`endif
    );

    imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(D)) u_wrap (
        .clk(clk), .rst(rst_w), .start(start_w),
        .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_instr(out_instr_w), .out_pc(out_pc_w),
        .dbg_req(1'b0), .dbg_addr(32'h0),
        .dbg_ack(dbg_ack_w), .dbg_rdata(dbg_rdata_w)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(fetch_cnt_w)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 = idle, 1 = running, 2 = servicing a debug read.
    int          m_mode, m_ret;
    logic [31:0] m_pc, m_drd, m_cnt;
    logic [63:0] m_q[$];
    logic        m_ack, last_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ret = 0; m_pc = 32'h0; m_drd = '0; m_cnt = '0;
        m_ack = 1'b0; last_ack = 1'b0;
        m_q.delete();
    endtask

    task automatic model_check();
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_pc", out_pc, m_q[0][63:32]);
            chk("out_instr", out_instr, m_q[0][31:0]);
        end
        chk("imem_addr", imem_addr, (m_mode == 2) ? {dbg_addr[31:2], 2'b00} : m_pc);
        chk("dbg_ack", 32'(dbg_ack), 32'(m_ack));
        chk("dbg_rdata", dbg_rdata, m_drd);
`ifdef FETCH_CNT_EN
        chk("fetch_cnt", fetch_cnt, m_cnt);
`endif
    endtask

    task automatic model_update();
        bit pop, dbg_ok;
        int nxt;
        pop    = (m_q.size() != 0) && out_ready;
        dbg_ok = dbg_req && !redirect_valid && !m_ack;
        nxt    = m_mode;
        last_ack = m_ack;
        m_ack  = (m_mode == 2);
        if (m_mode == 2) m_drd = mem_word({dbg_addr[31:2], 2'b00});
        case (m_mode)
            0: begin
                if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
                if (dbg_ok) begin nxt = 2; m_ret = start ? 1 : 0; end
                else if (start) nxt = 1;
            end
            1: begin
                if (redirect_valid) begin
                    m_q.delete();
                    m_pc = {redirect_pc[31:2], 2'b00};
                end else begin
                    if (pop) void'(m_q.pop_front());
                    if (m_q.size() < D) begin
                        m_q.push_back({m_pc, mem_word(m_pc)});
                        m_pc  = m_pc + 32'd4;
                        m_cnt = m_cnt + 32'd1;
                    end
                end
                if (dbg_ok) begin nxt = 2; m_ret = 1; end
            end
            default: begin
                if (redirect_valid) begin
                    m_q.delete();
                    m_pc = {redirect_pc[31:2], 2'b00};
                end else if (pop) begin
                    void'(m_q.pop_front());
                end
                nxt = m_ret;
            end
        endcase
        m_mode = nxt;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; asserts reset between edges.
    task automatic apply_reset();
        start = 0; redirect_valid = 0; dbg_req = 0; out_ready = 0;
        #2 rst = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async dbg_ack", 32'(dbg_ack), 32'd0);
        repeat (3) @(posedge clk);
        chk("held dbg_ack", 32'(dbg_ack), 32'd0);
        #1 rst = 1'b1;
        model_reset();
    endtask

    logic [31:0] wrap_pc[4];
    int          got;

    initial begin
        apply_reset();
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset out_instr", out_instr, 32'h0);
        chk("reset dbg_rdata", dbg_rdata, 32'h0);

        // Start and stream with decode always ready.
        out_ready = 1; start = 1; cycle(); start = 0; cycle();
        chk("first out_valid", 32'(out_valid), 32'd1);
        chk("first out_pc", out_pc, 32'h0);
        chk("first out_instr", out_instr, 32'h1000_0000);
        repeat (6) cycle();

        // Backpressure: two words buffered, PC parked at 8.
        apply_reset();
        start = 1; cycle(); start = 0;
        repeat (4) cycle();
        chk("bp imem_addr", imem_addr, 32'h8);
        chk("bp out_pc", out_pc, 32'h0);
        out_ready = 1;
        repeat (6) cycle();

        // Redirect flushes the buffered entries, head included.
        out_ready = 0; repeat (3) cycle();
        out_ready = 1; redirect_valid = 1; redirect_pc = 32'h43; cycle();
        redirect_valid = 0; cycle();
        chk("redir out_pc", out_pc, 32'h40);
        chk("redir out_instr", out_instr, 32'h1000_0010);
        repeat (3) cycle();

        // Debug read interleaved with the stream.
        dbg_req = 1; dbg_addr = 32'h10; cycle(); cycle();
        chk("dbg ack pulse", 32'(dbg_ack), 32'd1);
        chk("dbg rdata", dbg_rdata, 32'h1000_0004);
        cycle(); dbg_req = 0;
        repeat (4) cycle();

        // Asynchronous reset while a debug read is in flight.
        dbg_req = 1; dbg_addr = 32'h24; cycle();
        apply_reset();
        cycle();
        out_ready = 1; start = 1; cycle(); start = 0;
        repeat (4) cycle();

        // Randomized traffic, beginning from IDLE.
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                         : 32'($urandom);
            start          = ($urandom_range(0, 7) == 0);
            if (!dbg_req && $urandom_range(0, 7) == 0) begin
                dbg_req  = 1;
                dbg_addr = 32'($urandom);
            end
            cycle();
            if (last_ack) dbg_req = 0;
        end
        start = 0; redirect_valid = 0; dbg_req = 0;

        // PC wrap on the second instance.
        @(posedge clk); #1;
        rst_w = 1; out_ready_w = 1; start_w = 1;
        @(posedge clk); #1 start_w = 0;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (out_valid_w) begin
                wrap_pc[got] = out_pc_w;
                got++;
`ifdef FETCH_CNT_EN
                if (got == 4) chk("wrap fetch_cnt", fetch_cnt_w, 32'd4);
`endif
            end
        end
        chk("wrap count", 32'(got), 32'd4);
        if (got == 4) begin
            chk("wrap pc0", wrap_pc[0], 32'hFFFF_FFF8);
            chk("wrap pc1", wrap_pc[1], 32'hFFFF_FFFC);
            chk("wrap pc2", wrap_pc[2], 32'h0000_0000);
            chk("wrap pc3", wrap_pc[3], 32'h0000_0004);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
